// File: rtl/bus_master_if_pkg.sv
// Shared bus header: bus widths, active-low signal levels, read/write encoding
// and the master-port FSM state encoding.
package bus_master_if_pkg;

    localparam int BUS_ADDR_W = 30;
    localparam int BUS_DATA_W = 32;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        WAIT   = 2'd3
    } bus_state_e;

endpackage

// File: rtl/bus_master_if.sv
// CPU-side bus master port: turns a one-cycle pipeline memory request into a
// request/grant/strobe/ready bus transaction and stalls the stage meanwhile.
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic              cpuAs_,
    input  logic              cpuRW,
    input  logic [DATA_W-1:0] cpuWrData,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] cpuRdData,
    output logic              cpuBusy,
    output logic              busReq_,
    input  logic              busGrnt_,
    output logic [ADDR_W-1:0] busAddr,
    output logic              busAs_,
    output logic              busRW,
    output logic [DATA_W-1:0] busWrData,
    input  logic [DATA_W-1:0] busRdData,
    input  logic              busRdy_
);

    bus_state_e        state, state_nxt;
    logic [DATA_W-1:0] rd_buf, rd_buf_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wr_data_nxt;
    logic              rw_nxt, req_nxt, as_nxt;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        rd_buf_nxt  = rd_buf;
        addr_nxt    = busAddr;
        wr_data_nxt = busWrData;
        rw_nxt      = busRW;
        req_nxt     = busReq_;
        as_nxt      = busAs_;
        cpuBusy     = 1'b0;
        cpuRdData   = rd_buf;

        case (state)
            IDLE: begin
                if (cpuAs_ == ENABLE_ && !flush) begin
                    addr_nxt    = cpuAddr;
                    rw_nxt      = cpuRW;
                    wr_data_nxt = cpuWrData;
                    req_nxt     = ENABLE_;
                    state_nxt   = REQ;
                    cpuBusy     = 1'b1;
                end
            end
            REQ: begin
                cpuBusy = 1'b1;
                // Flush wins over a same-cycle grant: nothing has reached the bus yet.
                if (flush) begin
                    req_nxt   = DISABLE_;
                    state_nxt = IDLE;
                end else if (busGrnt_ == ENABLE_) begin
                    as_nxt    = ENABLE_;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                as_nxt = DISABLE_;
                if (busRdy_ == ENABLE_) begin
                    req_nxt   = DISABLE_;
                    cpuRdData = busRdData;
                    if (busRW == READ) begin
                        rd_buf_nxt = busRdData;
                    end
                    state_nxt = stall ? WAIT : IDLE;
                end else begin
                    cpuBusy = 1'b1;
                end
            end
            WAIT: begin
                if (!stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busReq_   <= DISABLE_;
            busAs_    <= DISABLE_;
            busRW     <= READ;
            busAddr   <= '0;
            busWrData <= '0;
            rd_buf    <= '0;
        end else begin
            state     <= state_nxt;
            busReq_   <= req_nxt;
            busAs_    <= as_nxt;
            busRW     <= rw_nxt;
            busAddr   <= addr_nxt;
            busWrData <= wr_data_nxt;
            rd_buf    <= rd_buf_nxt;
        end
    end

endmodule
